// File: rtl/iter_divider_hs.sv
`default_nettype none
// ============================================================================
// Module     : iter_divider_hs
// Description: Multi-cycle restoring integer divider, signed/unsigned per
//              request, valid/ready handshakes, div-by-zero/overflow flags.
// Revision   : 1.0
// ============================================================================
module iter_divider_hs #(
    parameter int N              = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_dividend,
    input  logic [N-1:0] in_divisor,
    input  logic         in_signed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_quotient,
    output logic [N-1:0] out_remainder,
    output logic         out_div_by_zero,
    output logic         out_overflow,
    output logic         busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CALC  = 2'd1;
    localparam logic [1:0] c_FIXUP = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam int                 c_STEPS    = N / BITS_PER_CYCLE;
    localparam int                 c_CNT_W    = $clog2(c_STEPS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(c_STEPS);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [N-1:0]       c_MIN      = {1'b1, {(N-1){1'b0}}};

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [N-1:0]       r_quot;
    logic [N-1:0]       r_rem;
    logic [N-1:0]       r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [N-1:0]       r_out_q;
    logic [N-1:0]       r_out_r;
    logic               r_dbz;
    logic               r_ovf;
    logic               r_valid;

    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [N-1:0]       w_dvd_abs;
    logic [N-1:0]       w_dvs_abs;
    logic               w_div_zero;
    logic               w_ovf_case;

    logic [N-1:0]       w_rem_acc;
    logic [N-1:0]       w_q_acc;
    logic [N:0]         w_trial;
    logic [N:0]         w_diff;

    assign w_dvd_neg  = in_signed & in_dividend[N-1];
    assign w_dvs_neg  = in_signed & in_divisor[N-1];
    assign w_dvd_abs  = w_dvd_neg ? -in_dividend : in_dividend;
    assign w_dvs_abs  = w_dvs_neg ? -in_divisor  : in_divisor;
    assign w_div_zero = (in_divisor == '0);
    assign w_ovf_case = in_signed & (in_dividend == c_MIN) & (in_divisor == '1);

    // Chained restoring steps; the borrow of the N+1-bit trial subtraction
    // decides whether the step restores.
    always_comb begin
        w_rem_acc = r_rem;
        w_q_acc   = r_quot;
        w_trial   = '0;
        w_diff    = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            w_trial = {w_rem_acc, w_q_acc[N-1]};
            w_diff  = w_trial - {1'b0, r_div};
            w_rem_acc = w_diff[N] ? w_trial[N-1:0] : w_diff[N-1:0];
            w_q_acc   = {w_q_acc[N-2:0], ~w_diff[N]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_out_q <= '0;
            r_out_r <= '0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        if (w_div_zero) begin
                            r_out_q <= '1;
                            r_out_r <= in_dividend;
                            r_dbz   <= 1'b1;
                            r_ovf   <= 1'b0;
                            r_state <= c_DONE;
                        end else if (w_ovf_case) begin
                            r_out_q <= in_dividend;
                            r_out_r <= '0;
                            r_dbz   <= 1'b0;
                            r_ovf   <= 1'b1;
                            r_state <= c_DONE;
                        end else begin
                            r_quot  <= w_dvd_abs;
                            r_rem   <= '0;
                            r_div   <= w_dvs_abs;
                            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                            r_neg_r <= w_dvd_neg;
                            r_dbz   <= 1'b0;
                            r_ovf   <= 1'b0;
                            r_cnt   <= c_CNT_LOAD;
                            r_state <= c_CALC;
                        end
                    end
                end
                c_CALC: begin
                    r_rem  <= w_rem_acc;
                    r_quot <= w_q_acc;
                    r_cnt  <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= c_FIXUP;
                    end
                end
                c_FIXUP: begin
                    r_out_q <= r_neg_q ? -r_quot : r_quot;
                    r_out_r <= r_neg_r ? -r_rem  : r_rem;
                    r_state <= c_DONE;
                end
                c_DONE: begin
                    // Results land on DONE entry; valid follows one cycle later.
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_valid <= 1'b0;
                        r_dbz   <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready        = (r_state == c_IDLE);
    assign busy            = (r_state != c_IDLE);
    assign out_valid       = r_valid;
    assign out_quotient    = r_out_q;
    assign out_remainder   = r_out_r;
    assign out_div_by_zero = r_dbz;
    assign out_overflow    = r_ovf;

endmodule
`default_nettype wire
